// File: rtl/add_seq_pkg.sv
// Shared definitions for the byte-serial add sequencer: FSM states, slice width
// and the slice-index width helper.
package add_seq_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    // Index width for NBYTES slices; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/fulladder_8.sv
// Purely combinational 8-bit ripple-carry adder, shared across all byte slices.
module fulladder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[8];
    end

endmodule

// File: rtl/add8_seq_ctrl.sv
// Multi-byte adder that feeds one slice per cycle through a shared fulladder_8,
// LSB first, chaining the carry through carry_q between cycles.
module add8_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4,
    localparam int unsigned W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int unsigned IW = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    add_state_t state, state_nx;

    logic [IW-1:0]      idx;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [SLICE_W-1:0] fa_a;
    logic [SLICE_W-1:0] fa_b;
    logic [SLICE_W-1:0] fa_sum;
    logic               fa_cout;
    logic               accept;
    logic               last;

    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN) || (state == DONE);
    assign accept   = in_valid && in_ready;
    assign last     = (idx == LAST);

    // Slice mux compares idx against constant slice numbers so every part
    // select has a fixed base.
    always_comb begin
        fa_a = '0;
        fa_b = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                fa_a = a_q[SLICE_W*i +: SLICE_W];
                fa_b = b_q[SLICE_W*i +: SLICE_W];
            end
        end
    end

    fulladder_8 u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (idx == IW'(i)) sum[SLICE_W*i +: SLICE_W] <= fa_sum;
                    end
                    carry_q <= fa_cout;
                    if (last) begin
                        idx       <= '0;
                        cout      <= fa_cout;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(idx) < int'(NBYTES));

endmodule
